gol_sim_ctrl: RTL and testbench



---
 rtl/gol_sim_ctrl.sv | 166 ++++++++++++++++
 tb/tb_gol_sim_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gol_sim_ctrl.sv
// rtl/gol_sim_ctrl.sv - Game of Life control core: arbitrates config loads, run/pause/step
// pacing and ping-pong field selection for the iterator and loader.
module gol_sim_ctrl #(
    parameter int CFG_CNT   = 2,
    parameter int PERIOD_W  = 32,
    parameter int GEN_CNT_W = 16,
    parameter int SEL_W     = $clog2(CFG_CNT + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_cmd_toggle_pause,
    input  logic                 i_cmd_step,
    input  logic [CFG_CNT-1:0]   i_cmd_load_cfg,
    input  logic [PERIOD_W-1:0]  i_period,
    output logic                 o_nfi_go,
    input  logic                 i_nfi_busy,
    output logic                 o_fcl_go,
    output logic [SEL_W-1:0]     o_fcl_sel,
    input  logic                 i_fcl_busy,
    output logic                 o_read_field,
    output logic                 o_paused,
    output logic [GEN_CNT_W-1:0] o_gen_cnt,
    output logic                 o_busy
);

    typedef enum logic [2:0] {
        BOOT,
        IDLE,
        LOAD_START,
        LOAD_WAIT,
        SIM_START,
        SIM_WAIT
    } state_t;

    state_t                 r_state;
    logic                   r_nfi_go;
    logic                   r_fcl_go;
    logic [SEL_W-1:0]       r_fcl_sel;
    logic                   r_read_field;
    logic                   r_paused;
    logic [GEN_CNT_W-1:0]   r_gen_cnt;
    logic                   r_load_pend;
    logic [SEL_W-1:0]       r_load_idx;
    logic                   r_step_pend;
    logic [PERIOD_W-1:0]    r_pcnt;

    logic [SEL_W-1:0]       w_load_idx;
    logic                   w_load_req;
    logic [PERIOD_W-1:0]    w_period_m1;
    logic                   w_tick_due;
    logic                   w_pcnt_run;

    // Descending scan so the lowest set request bit is the one that sticks.
    always_comb begin
        w_load_idx = '0;
        for (int k = CFG_CNT - 1; k >= 0; k--) begin
            if (i_cmd_load_cfg[k]) begin
                w_load_idx = SEL_W'(k + 1);
            end
        end
    end

    assign w_load_req  = |i_cmd_load_cfg;
    assign w_period_m1 = (i_period == '0) ? '0 : i_period - PERIOD_W'(1);
    assign w_tick_due  = (r_pcnt >= w_period_m1);
    assign w_pcnt_run  = !r_paused &&
                         (r_state == IDLE || r_state == SIM_START || r_state == SIM_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= BOOT;
            r_nfi_go     <= 1'b0;
            r_fcl_go     <= 1'b0;
            r_fcl_sel    <= '0;
            r_read_field <= 1'b0;
            r_paused     <= 1'b1;
            r_gen_cnt    <= '0;
            r_load_pend  <= 1'b0;
            r_load_idx   <= '0;
            r_step_pend  <= 1'b0;
            r_pcnt       <= '0;
        end else begin
            r_nfi_go <= 1'b0;
            r_fcl_go <= 1'b0;

            if (w_pcnt_run && r_pcnt != '1) begin
                r_pcnt <= r_pcnt + PERIOD_W'(1);
            end

            if (i_cmd_toggle_pause) begin
                r_paused <= ~r_paused;
            end

            case (r_state)
                BOOT: begin
                    r_fcl_go  <= 1'b1;
                    r_fcl_sel <= '0;
                    r_state   <= LOAD_START;
                end
                IDLE: begin
                    if (r_load_pend) begin
                        r_fcl_go    <= 1'b1;
                        r_fcl_sel   <= r_load_idx;
                        r_load_pend <= 1'b0;
                        r_state     <= LOAD_START;
                    end else if (r_paused && r_step_pend) begin
                        r_nfi_go    <= 1'b1;
                        r_step_pend <= 1'b0;
                        r_state     <= SIM_START;
                    end else if (!r_paused && w_tick_due) begin
                        r_nfi_go <= 1'b1;
                        r_pcnt   <= '0;
                        r_state  <= SIM_START;
                    end
                end
                LOAD_START: begin
                    if (i_fcl_busy) begin
                        r_state <= LOAD_WAIT;
                    end
                end
                LOAD_WAIT: begin
                    if (!i_fcl_busy) begin
                        r_gen_cnt <= '0;
                        r_pcnt    <= '0;
                        r_state   <= IDLE;
                    end
                end
                SIM_START: begin
                    if (i_nfi_busy) begin
                        r_state <= SIM_WAIT;
                    end
                end
                SIM_WAIT: begin
                    if (!i_nfi_busy) begin
                        r_read_field <= ~r_read_field;
                        if (r_gen_cnt != '1) begin
                            r_gen_cnt <= r_gen_cnt + GEN_CNT_W'(1);
                        end
                        r_state <= IDLE;
                    end
                end
                default: r_state <= BOOT;
            endcase

            // Capture after the FSM so a fresh request overrides the clear on issue.
            if (w_load_req) begin
                r_load_pend <= 1'b1;
                r_load_idx  <= w_load_idx;
            end
            if (i_cmd_toggle_pause && r_paused) begin
                r_step_pend <= 1'b0;
            end else if (i_cmd_step && r_paused) begin
                r_step_pend <= 1'b1;
            end
        end
    end

    assign o_nfi_go     = r_nfi_go;
    assign o_fcl_go     = r_fcl_go;
    assign o_fcl_sel    = r_fcl_sel;
    assign o_read_field = r_read_field;
    assign o_paused     = r_paused;
    assign o_gen_cnt    = r_gen_cnt;
    assign o_busy       = (r_state != IDLE);

endmodule

// File: tb/tb_gol_sim_ctrl.sv
// tb/tb_gol_sim_ctrl.sv - directed bench for gol_sim_ctrl with a go-pulse scoreboard
// and behavioural iterator/loader busy responders.
module tb_gol_sim_ctrl;

    localparam int CFG_CNT   = 2;
    localparam int PERIOD_W  = 32;
    localparam int GEN_CNT_W = 16;
    localparam int SEL_W     = $clog2(CFG_CNT + 1);

    logic                 clk;
    logic                 rst_n;
    logic                 i_cmd_toggle_pause;
    logic                 i_cmd_step;
    logic [CFG_CNT-1:0]   i_cmd_load_cfg;
    logic [PERIOD_W-1:0]  i_period;
    logic                 o_nfi_go;
    logic                 i_nfi_busy;
    logic                 o_fcl_go;
    logic [SEL_W-1:0]     o_fcl_sel;
    logic                 i_fcl_busy;
    logic                 o_read_field;
    logic                 o_paused;
    logic [GEN_CNT_W-1:0] o_gen_cnt;
    logic                 o_busy;

    gol_sim_ctrl #(
        .CFG_CNT  (CFG_CNT),
        .PERIOD_W (PERIOD_W),
        .GEN_CNT_W(GEN_CNT_W)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_cmd_toggle_pause(i_cmd_toggle_pause),
        .i_cmd_step        (i_cmd_step),
        .i_cmd_load_cfg    (i_cmd_load_cfg),
        .i_period          (i_period),
        .o_nfi_go          (o_nfi_go),
        .i_nfi_busy        (i_nfi_busy),
        .o_fcl_go          (o_fcl_go),
        .o_fcl_sel         (o_fcl_sel),
        .i_fcl_busy        (i_fcl_busy),
        .o_read_field      (o_read_field),
        .o_paused          (o_paused),
        .o_gen_cnt         (o_gen_cnt),
        .o_busy            (o_busy)
    );

    typedef struct {
        bit is_load;
        int sel;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  fcl_len = 10;
    int  nfi_len = 20;
    int  fcnt = 0;
    int  ncnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Iterator and loader stand-ins: busy for a fixed span after each go pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            fcnt = 0;
            ncnt = 0;
        end else begin
            if (o_fcl_go) fcnt = fcl_len;
            else if (fcnt > 0) fcnt--;
            if (o_nfi_go) ncnt = nfi_len;
            else if (ncnt > 0) ncnt--;
        end
        i_fcl_busy = (fcnt > 0);
        i_nfi_busy = (ncnt > 0);
    end

    // Every go pulse must match the next expected event in issue order.
    always @(negedge clk) begin
        if (rst_n && (o_fcl_go || o_nfi_go)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_go", {62'd0, o_fcl_go, o_nfi_go}, 64'd0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("go_kind_is_load", {63'd0, o_fcl_go}, {63'd0, e.is_load});
                chk("go_both_high", {63'd0, o_fcl_go & o_nfi_go}, 64'd0);
                if (e.is_load) chk("fcl_sel", 64'(o_fcl_sel), 64'(e.sel));
            end
        end
    end

    task automatic push(input bit is_load, input int sel);
        ev_t e;
        e.is_load = is_load;
        e.sel     = sel;
        exp_q.push_back(e);
    endtask

    task automatic pulse_toggle();
        i_cmd_toggle_pause = 1'b1;
        @(negedge clk);
        i_cmd_toggle_pause = 1'b0;
    endtask

    task automatic pulse_step();
        i_cmd_step = 1'b1;
        @(negedge clk);
        i_cmd_step = 1'b0;
    endtask

    task automatic pulse_load(input logic [CFG_CNT-1:0] v);
        i_cmd_load_cfg = v;
        @(negedge clk);
        i_cmd_load_cfg = '0;
    endtask

    task automatic wait_go(input bit is_load, input string tag, output int at);
        at = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (is_load ? o_fcl_go : o_nfi_go) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk({tag, "_timeout"}, 64'd1, 64'd0);
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!o_busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk({tag, "_idle_timeout"}, 64'd1, 64'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_nfi_go"}, 64'(o_nfi_go), 64'd0);
        chk({tag, "_fcl_go"}, 64'(o_fcl_go), 64'd0);
        chk({tag, "_fcl_sel"}, 64'(o_fcl_sel), 64'd0);
        chk({tag, "_read_field"}, 64'(o_read_field), 64'd0);
        chk({tag, "_paused"}, 64'(o_paused), 64'd1);
        chk({tag, "_gen_cnt"}, 64'(o_gen_cnt), 64'd0);
        chk({tag, "_busy"}, 64'(o_busy), 64'd1);
    endtask

    initial begin
        int t0;
        int t1;
        int n;
        bit ok;

        rst_n              = 1'b1;
        i_cmd_toggle_pause = 1'b0;
        i_cmd_step         = 1'b0;
        i_cmd_load_cfg     = '0;
        i_period           = 32'd100;
        #3 rst_n = 1'b0;

        // Reset and boot clear-field load
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        push(1'b1, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("boot_fcl_go", 64'(o_fcl_go), 64'd1);
        chk("boot_fcl_sel", 64'(o_fcl_sel), 64'd0);
        wait_idle("boot");
        chk("boot_paused", 64'(o_paused), 64'd1);
        chk("boot_gen_cnt", 64'(o_gen_cnt), 64'd0);
        chk("boot_read_field", 64'(o_read_field), 64'd0);

        // Free run at period 100
        for (int g = 0; g < 3; g++) push(1'b0, 0);
        pulse_toggle();
        chk("run_paused", 64'(o_paused), 64'd0);
        t0 = 0;
        for (int g = 1; g <= 3; g++) begin
            wait_go(1'b0, "run_go", t1);
            if (g > 1) chk("run_interval", 64'(t1 - t0), 64'd100);
            t0 = t1;
            wait_idle("run");
            chk("run_gen_cnt", 64'(o_gen_cnt), 64'(g));
            chk("run_read_field", 64'(o_read_field), 64'(g % 2));
        end
        pulse_toggle();
        chk("pause_paused", 64'(o_paused), 64'd1);

        // Step while paused; extra steps during SIM_WAIT collapse into one
        push(1'b0, 0);
        pulse_step();
        wait_go(1'b0, "step_go", t1);
        push(1'b0, 0);
        @(negedge clk);
        pulse_step();
        pulse_step();
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (o_gen_cnt == 16'd5) begin
                ok = 1'b1;
                break;
            end
        end
        chk("step_reach5", 64'(ok), 64'd1);
        repeat (40) @(negedge clk);
        chk("step_gen_cnt", 64'(o_gen_cnt), 64'd5);
        chk("step_busy", 64'(o_busy), 64'd0);

        // Load 2'b11 during SIM_WAIT: sim finishes, then config 1 loads
        push(1'b0, 0);
        push(1'b1, 1);
        pulse_step();
        wait_go(1'b0, "ld_sim_go", t1);
        @(negedge clk);
        pulse_load(2'b11);
        wait_go(1'b1, "ld_go", t1);
        chk("ld_pre_gen_cnt", 64'(o_gen_cnt), 64'd6);
        wait_idle("ld");
        chk("ld_gen_cnt", 64'(o_gen_cnt), 64'd0);
        chk("ld_read_field", 64'(o_read_field), 64'd0);

        // Load and run tick both due in one IDLE cycle: load wins
        i_period = 32'd5;
        push(1'b0, 0);
        push(1'b1, 2);
        push(1'b0, 0);
        pulse_toggle();
        wait_go(1'b0, "arb_sim_go", t1);
        @(negedge clk);
        pulse_load(2'b10);
        wait_go(1'b1, "arb_ld_go", t1);
        wait_idle("arb_ld");
        n = cyc;
        wait_go(1'b0, "arb_sim2_go", t1);
        chk("arb_post_load_latency", 64'(t1 - n), 64'd5);
        pulse_toggle();
        chk("arb_paused", 64'(o_paused), 64'd1);
        wait_idle("arb");
        chk("arb_gen_cnt", 64'(o_gen_cnt), 64'd1);
        chk("arb_read_field", 64'(o_read_field), 64'd0);
        repeat (30) @(negedge clk);
        chk("arb_quiet_busy", 64'(o_busy), 64'd0);

        // Reset mid SIM_WAIT
        push(1'b0, 0);
        pulse_step();
        wait_go(1'b0, "rst2_sim_go", t1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst2");
        repeat (3) @(negedge clk);
        push(1'b1, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst2_fcl_go", 64'(o_fcl_go), 64'd1);
        chk("rst2_fcl_sel", 64'(o_fcl_sel), 64'd0);
        wait_idle("rst2");
        chk("rst2_gen_cnt", 64'(o_gen_cnt), 64'd0);
        chk("rst2_read_field", 64'(o_read_field), 64'd0);
        chk("rst2_paused", 64'(o_paused), 64'd1);
        repeat (20) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
